// File: rtl/fact_seq_pkg.sv
// Shared types and constants for the factorial sequencing controller.
package fact_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_START,
    ST_WAIT,
    ST_LOAD
  } fact_seq_state_t;

  // All-ones value of the given width, used to mark a saturated result.
  function automatic logic [63:0] sat_val(input int size);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < size) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/input_settle.sv
// Switch debouncer: tracks a candidate operand and flags it once it has held
// steady for SETTLE_CYCLES consecutive cycles while the sequencer is settling.
module input_settle #(
  parameter int SIZE          = 8,
  parameter int SETTLE_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_active,
  input  logic [SIZE-1:0] i_n,
  output logic            stable_pulse,
  output logic [SIZE-1:0] stable_val
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [SIZE-1:0]  r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic             w_same;

  assign w_same = (i_n == r_cand);

  // Any change of the switches restarts the stability count from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand <= '0;
      r_cnt  <= '0;
    end else if (i_load || (i_active && !w_same)) begin
      r_cand <= i_n;
      r_cnt  <= '0;
    end else if (i_active && (r_cnt != CNT_LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign stable_pulse = i_active && w_same && (r_cnt == CNT_LAST);
  assign stable_val   = r_cand;

endmodule

// File: rtl/factorial_seq.sv
// Sequencer between switches, factorial datapath and display path.
// Define FACT_SEQ_TIMEOUT_EN to add the WAIT-state watchdog and the err path.
module factorial_seq #(
  parameter int SIZE          = 8,
  parameter int N_MAX         = 5,
  parameter int SETTLE_CYCLES = 1000000
`ifdef FACT_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] n_in,
  output logic            fact_go,
  output logic [SIZE-1:0] fact_n,
  input  logic            fact_done,
  input  logic [SIZE-1:0] fact_result,
  input  logic            disp_busy,
  output logic            disp_ld,
  output logic [SIZE-1:0] disp_value,
  output logic            ovf,
  output logic            err,
  output logic            busy
);
  import fact_seq_pkg::*;

  localparam logic [SIZE-1:0] SAT    = SIZE'(sat_val(SIZE));
  localparam logic [SIZE-1:0] NMAX_V = SIZE'(N_MAX);

  fact_seq_state_t r_state, w_next;
  logic            r_first, r_fact_go, r_disp_ld, r_busy, r_ovf;
  logic [SIZE-1:0] r_last_n, r_res, r_fact_n, r_disp_value;
  logic            w_start_settle, w_settle_active, w_stable_pulse, w_over;
  logic            w_timeout, w_fire, w_ovf_d;
  logic [SIZE-1:0] w_stable_val, w_res_d;

  assign w_start_settle  = (r_state == ST_IDLE) && (r_first || (n_in != r_last_n));
  assign w_settle_active = (r_state == ST_SETTLE);
  assign w_over          = (w_stable_val > NMAX_V);

  input_settle #(
    .SIZE          (SIZE),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_start_settle),
    .i_active     (w_settle_active),
    .i_n          (n_in),
    .stable_pulse (w_stable_pulse),
    .stable_val   (w_stable_val)
  );

`ifdef FACT_SEQ_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd;
  logic            r_err, w_err_d;

  assign w_timeout = (r_state == ST_WAIT) && !fact_done && (r_wd == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst || (r_state == ST_START)) begin
      r_wd <= '0;
    end else if ((r_state == ST_WAIT) && (r_wd != WD_LAST)) begin
      r_wd <= r_wd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_err_d;
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // fact_done during START is deliberately ignored; only WAIT listens for it.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_start_settle) w_next = ST_SETTLE;
      ST_SETTLE: if (w_stable_pulse) w_next = w_over ? ST_LOAD : ST_START;
      ST_START:  w_next = ST_WAIT;
      ST_WAIT:   if (fact_done || w_timeout) w_next = ST_LOAD;
      ST_LOAD:   if (r_disp_ld) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_res_d = r_res;
    w_ovf_d = r_ovf;
`ifdef FACT_SEQ_TIMEOUT_EN
    w_err_d = r_err;
`endif
    if (w_settle_active && w_stable_pulse && w_over) begin
      w_res_d = SAT;
      w_ovf_d = 1'b1;
`ifdef FACT_SEQ_TIMEOUT_EN
      w_err_d = 1'b0;
`endif
    end else if ((r_state == ST_WAIT) && fact_done) begin
      w_res_d = fact_result;
      w_ovf_d = 1'b0;
`ifdef FACT_SEQ_TIMEOUT_EN
      w_err_d = 1'b0;
`endif
    end else if (w_timeout) begin
      w_res_d = SAT;
      w_ovf_d = 1'b0;
`ifdef FACT_SEQ_TIMEOUT_EN
      w_err_d = 1'b1;
`endif
    end
    // Strobe is registered, so it is decided on the edge that enters the load cycle.
    w_fire = (w_next == ST_LOAD) && !disp_busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_first      <= 1'b1;
      r_last_n     <= '0;
      r_res        <= '0;
      r_ovf        <= 1'b0;
      r_fact_go    <= 1'b0;
      r_fact_n     <= '0;
      r_disp_ld    <= 1'b0;
      r_disp_value <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_res     <= w_res_d;
      r_ovf     <= w_ovf_d;
      r_fact_go <= (w_next == ST_START);
      r_busy    <= (w_next != ST_IDLE);
      r_disp_ld <= w_fire;
      if (w_fire) r_disp_value <= w_res_d;
      if (w_settle_active && w_stable_pulse) begin
        r_last_n <= w_stable_val;
        r_first  <= 1'b0;
        if (!w_over) r_fact_n <= w_stable_val;
      end
    end
  end

  assign fact_go    = r_fact_go;
  assign fact_n     = r_fact_n;
  assign disp_ld    = r_disp_ld;
  assign disp_value = r_disp_value;
  assign ovf        = r_ovf;
  assign busy       = r_busy;

endmodule

// File: tb/tb_factorial_seq.sv
// Bench for factorial_seq: drives switches, models the datapath and display,
// and compares against a factorial reference model (SETTLE=4, TIMEOUT=16).
module tb_factorial_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] n_in;
  logic       fact_go;
  logic [7:0] fact_n;
  logic       fact_done;
  logic [7:0] fact_result;
  logic       disp_busy;
  logic       disp_ld;
  logic [7:0] disp_value;
  logic       ovf;
  logic       err;
  logic       busy;

  factorial_seq #(
    .SIZE          (8),
    .N_MAX         (5),
    .SETTLE_CYCLES (4)
`ifdef FACT_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .n_in        (n_in),
    .fact_go     (fact_go),
    .fact_n      (fact_n),
    .fact_done   (fact_done),
    .fact_result (fact_result),
    .disp_busy   (disp_busy),
    .disp_ld     (disp_ld),
    .disp_value  (disp_value),
    .ovf         (ovf),
    .err         (err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         goCount = 0;
  int         goCyc = -1;
  logic [7:0] goN;
  int         ldCount = 0;
  int         ldCyc = -1;
  logic [7:0] ldVal;
  logic       ldOvf;
  logic       ldErr;
  int         dpLatency = -1;
  int         dpGoCyc = -1;
  logic [7:0] dpN;
  int         busyTill = 0;

  // Reference: n! truncated to 8 bits, saturated when n exceeds N_MAX.
  function automatic logic [7:0] refFact(input int n);
    longint p;
    if (n > 5) return 8'hFF;
    p = 1;
    for (int i = 2; i <= n; i++) p = p * i;
    return p[7:0];
  endfunction

  // One cycle: sample outputs at the falling edge, then drive the datapath and display models.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (fact_go) begin
      goCount++;
      goCyc   = cyc;
      goN     = fact_n;
      dpGoCyc = cyc;
      dpN     = fact_n;
    end
    if (disp_ld) begin
      ldCount++;
      ldCyc = cyc;
      ldVal = disp_value;
      ldOvf = ovf;
      ldErr = err;
    end
    if (dpLatency >= 0 && dpGoCyc >= 0 && cyc == dpGoCyc + dpLatency) begin
      fact_done   = 1'b1;
      fact_result = refFact(int'(dpN));
    end else begin
      fact_done   = 1'b0;
      fact_result = 8'($urandom);
    end
    disp_busy = (cyc < busyTill);
  endtask

  task automatic test_reset();
    rst = 1'b1; n_in = 8'd3; fact_done = 1'b0; fact_result = '0; disp_busy = 1'b0;
    repeat (3) step();
    total++; if (fact_go !== 1'b0) begin bad++; $display("[TB] FAIL reset_fact_go got=%b want=0", fact_go); end
    total++; if (fact_n !== 8'd0) begin bad++; $display("[TB] FAIL reset_fact_n got=%0d want=0", fact_n); end
    total++; if (disp_ld !== 1'b0) begin bad++; $display("[TB] FAIL reset_disp_ld got=%b want=0", disp_ld); end
    total++; if (disp_value !== 8'd0) begin bad++; $display("[TB] FAIL reset_disp_value got=%0d want=0", disp_value); end
    total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%b want=0", ovf); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b want=0", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_basic();
    int relCyc, g0, l0;
    dpLatency = 3; g0 = goCount; l0 = ldCount;
    rst = 1'b0; relCyc = cyc;
    for (int i = 0; i < 30 && ldCount == l0; i++) step();
    total++; if (ldCount !== l0 + 1) begin bad++; $display("[TB] FAIL basic_ld_seen got=%0d want=%0d", ldCount - l0, 1); end
    total++; if (goCount !== g0 + 1) begin bad++; $display("[TB] FAIL basic_go_count got=%0d want=1", goCount - g0); end
    total++; if (goCyc !== relCyc + 5) begin bad++; $display("[TB] FAIL basic_go_cycle got=%0d want=%0d", goCyc, relCyc + 5); end
    total++; if (goN !== 8'd3) begin bad++; $display("[TB] FAIL basic_fact_n got=%0d want=3", goN); end
    total++; if (ldCyc !== goCyc + 4) begin bad++; $display("[TB] FAIL basic_ld_cycle got=%0d want=%0d", ldCyc, goCyc + 4); end
    total++; if ({ldVal, ldOvf, ldErr} !== {refFact(3), 2'b00}) begin bad++; $display("[TB] FAIL basic_display got=%0d/%b/%b want=%0d/0/0", ldVal, ldOvf, ldErr, refFact(3)); end
  endtask

  task automatic test_toggle();
    int holdCyc, g0, l0, lat;
    logic [7:0] pattern [6];
    pattern = '{8'd4, 8'd4, 8'd5, 8'd5, 8'd4, 8'd4};
    repeat (3) step();
    lat = int'($urandom_range(1, 4)); dpLatency = lat; g0 = goCount; l0 = ldCount;
    for (int i = 0; i < 6; i++) begin n_in = pattern[i]; step(); end
    n_in = 8'd5; holdCyc = cyc;
    for (int i = 0; i < 40 && ldCount == l0; i++) step();
    total++; if (goCount !== g0 + 1) begin bad++; $display("[TB] FAIL toggle_go_count got=%0d want=1", goCount - g0); end
    total++; if (goCyc !== holdCyc + 5) begin bad++; $display("[TB] FAIL toggle_go_cycle got=%0d want=%0d", goCyc, holdCyc + 5); end
    total++; if (goN !== 8'd5) begin bad++; $display("[TB] FAIL toggle_fact_n got=%0d want=5", goN); end
    total++; if (ldCount !== l0 + 1) begin bad++; $display("[TB] FAIL toggle_ld_seen got=%0d want=1", ldCount - l0); end
    total++; if (ldVal !== refFact(5)) begin bad++; $display("[TB] FAIL toggle_display got=%0d want=%0d", ldVal, refFact(5)); end
    total++; if (ldCyc !== goCyc + lat + 1) begin bad++; $display("[TB] FAIL toggle_ld_cycle got=%0d want=%0d", ldCyc, goCyc + lat + 1); end
  endtask

  task automatic test_overflow();
    int c0, g0, l0;
    repeat (3) step();
    g0 = goCount; l0 = ldCount;
    n_in = 8'd7; c0 = cyc;
    for (int i = 0; i < 30 && ldCount == l0; i++) step();
    total++; if (goCount !== g0) begin bad++; $display("[TB] FAIL ovf_no_go got=%0d want=0", goCount - g0); end
    total++; if (ldCount !== l0 + 1) begin bad++; $display("[TB] FAIL ovf_ld_seen got=%0d want=1", ldCount - l0); end
    total++; if (ldCyc !== c0 + 5) begin bad++; $display("[TB] FAIL ovf_ld_cycle got=%0d want=%0d", ldCyc, c0 + 5); end
    total++; if (ldVal !== 8'hFF) begin bad++; $display("[TB] FAIL ovf_display got=%0h want=ff", ldVal); end
    total++; if ({ldOvf, ldErr} !== 2'b10) begin bad++; $display("[TB] FAIL ovf_flags got=%b%b want=10", ldOvf, ldErr); end
  endtask

  task automatic test_timeout();
    int c0, g0, l0;
    repeat (3) step();
    g0 = goCount; l0 = ldCount; dpLatency = -1;
    n_in = 8'd4; c0 = cyc;
`ifdef FACT_SEQ_TIMEOUT_EN
    for (int i = 0; i < 60 && ldCount == l0; i++) step();
    total++; if (goCyc !== c0 + 5 || goN !== 8'd4) begin bad++; $display("[TB] FAIL wd_go got=%0d/%0d want=%0d/4", goCyc, goN, c0 + 5); end
    total++; if (ldCount !== l0 + 1) begin bad++; $display("[TB] FAIL wd_ld_seen got=%0d want=1", ldCount - l0); end
    total++; if (ldCyc !== goCyc + 17) begin bad++; $display("[TB] FAIL wd_ld_cycle got=%0d want=%0d", ldCyc, goCyc + 17); end
    total++; if ({ldVal, ldOvf, ldErr} !== {8'hFF, 2'b01}) begin bad++; $display("[TB] FAIL wd_display got=%0h/%b/%b want=ff/0/1", ldVal, ldOvf, ldErr); end
`else
    repeat (1000) step();
    total++; if (goCount !== g0 + 1) begin bad++; $display("[TB] FAIL nowd_go_count got=%0d want=1", goCount - g0); end
    total++; if (ldCount !== l0) begin bad++; $display("[TB] FAIL nowd_no_ld got=%0d want=0", ldCount - l0); end
    dpLatency = 2; l0 = ldCount;
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 30 && ldCount == l0; i++) step();
    total++; if (ldCount !== l0 + 1 || ldVal !== refFact(4)) begin bad++; $display("[TB] FAIL nowd_recover got=%0d/%0d want=1/%0d", ldCount - l0, ldVal, refFact(4)); end
`endif
  endtask

  task automatic test_busy_hold();
    int g0, l0;
    repeat (3) step();
    dpLatency = 2; busyTill = 1000000000; g0 = goCount; l0 = ldCount;
    n_in = 8'd2;
    for (int i = 0; i < 30 && goCount == g0; i++) step();
    busyTill = goCyc + 12;
    for (int i = 0; i < 40 && ldCount == l0; i++) step();
    total++; if (ldCount !== l0 + 1) begin bad++; $display("[TB] FAIL busy_ld_seen got=%0d want=1", ldCount - l0); end
    total++; if (ldCyc !== busyTill + 1) begin bad++; $display("[TB] FAIL busy_ld_cycle got=%0d want=%0d", ldCyc, busyTill + 1); end
    total++; if (ldVal !== refFact(2)) begin bad++; $display("[TB] FAIL busy_display got=%0d want=%0d", ldVal, refFact(2)); end
    g0 = goCount; l0 = ldCount;
    repeat (30) step();
    total++; if (goCount !== g0 || ldCount !== l0) begin bad++; $display("[TB] FAIL hold_no_retrigger got=%0d/%0d want=0/0", goCount - g0, ldCount - l0); end
  endtask

  task automatic test_reset_mid_wait();
    int g0, l0, relCyc;
    repeat (3) step();
    dpLatency = -1; g0 = goCount;
    n_in = 8'd1;
    for (int i = 0; i < 30 && goCount == g0; i++) step();
    repeat (3) step();
    rst = 1'b1; step();
    total++; if ({fact_go, fact_n, disp_ld, disp_value, ovf, err, busy} !== 21'd0) begin
      bad++; $display("[TB] FAIL midwait_reset_outputs got=%b/%0d/%b/%0d/%b/%b/%b want=all zero", fact_go, fact_n, disp_ld, disp_value, ovf, err, busy);
    end
    dpLatency = 2; g0 = goCount; l0 = ldCount;
    rst = 1'b0; relCyc = cyc;
    for (int i = 0; i < 30 && ldCount == l0; i++) step();
    total++; if (goCount !== g0 + 1 || goCyc !== relCyc + 5) begin bad++; $display("[TB] FAIL midwait_restart_go got=%0d@%0d want=1@%0d", goCount - g0, goCyc, relCyc + 5); end
    total++; if (goN !== 8'd1) begin bad++; $display("[TB] FAIL midwait_fact_n got=%0d want=1", goN); end
    total++; if (ldCount !== l0 + 1 || ldVal !== refFact(1)) begin bad++; $display("[TB] FAIL midwait_display got=%0d/%0d want=1/%0d", ldCount - l0, ldVal, refFact(1)); end
  endtask

  task automatic test_random();
    int n, prev, g0, l0;
    bit expOvf;
    prev = int'(n_in);
    for (int it = 0; it < 8; it++) begin
      repeat (3) step();
      if (it == 0) n = 0;
      else if (it == 1) n = 6;
      else begin
        n = prev;
        while (n == prev) n = int'($urandom_range(0, 9));
      end
      expOvf = (n > 5);
      dpLatency = int'($urandom_range(1, 6));
      busyTill = cyc + int'($urandom_range(0, 12));
      g0 = goCount; l0 = ldCount;
      n_in = 8'(n);
      for (int i = 0; i < 80 && ldCount == l0; i++) step();
      total++; if (ldCount !== l0 + 1) begin bad++; $display("[TB] FAIL rand_ld_seen n=%0d got=%0d want=1", n, ldCount - l0); end
      total++; if (ldVal !== refFact(n)) begin bad++; $display("[TB] FAIL rand_display n=%0d got=%0d want=%0d", n, ldVal, refFact(n)); end
      total++; if ({ldOvf, ldErr} !== {expOvf, 1'b0}) begin bad++; $display("[TB] FAIL rand_flags n=%0d got=%b%b want=%b0", n, ldOvf, ldErr, expOvf); end
      total++; if (goCount !== g0 + (expOvf ? 0 : 1)) begin bad++; $display("[TB] FAIL rand_go_count n=%0d got=%0d want=%0d", n, goCount - g0, expOvf ? 0 : 1); end
      if (!expOvf) begin
        total++; if (goN !== 8'(n)) begin bad++; $display("[TB] FAIL rand_fact_n got=%0d want=%0d", goN, n); end
      end
      prev = n;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_overflow();
    test_timeout();
    test_busy_hold();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL global_time_limit got=expired want=finished");
    $fatal(1, "[TB] time limit");
  end

endmodule
